// File: rtl/stride_decoder_if.sv
// Instruction and tap-stream bundle for stride_decoder.
//   master : instruction source / tap consumer (drives instruction fields,
//            inst_valid and mac_ready; observes everything else)
//   slave  : the decoder (accepts instructions, emits the tap stream)
// Widths: FRAM_ADDR_WIDTH feature-RAM word address, KRAM_ADDR_WIDTH
// kernel-RAM word address, DATA_WIDTH instruction dimension fields.

`ifndef FRAM_ADDR_WIDTH
`define FRAM_ADDR_WIDTH 16
`endif
`ifndef KRAM_BANKADDR_WIDTH
`define KRAM_BANKADDR_WIDTH 12
`endif

interface stride_decoder_if #(
  parameter int unsigned FRAM_ADDR_WIDTH = `FRAM_ADDR_WIDTH,
  parameter int unsigned KRAM_ADDR_WIDTH = `KRAM_BANKADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = 32
);

  // Instruction fields and handshake
  logic [FRAM_ADDR_WIDTH-1:0] stride_feature_baseaddr;
  logic [KRAM_ADDR_WIDTH-1:0] stride_kernel_baseaddr;
  logic [FRAM_ADDR_WIDTH-1:0] stride_wb_baseaddr;
  logic [DATA_WIDTH-1:0]      stride_feature_chin;
  logic [DATA_WIDTH-1:0]      stride_feature_chout;
  logic [DATA_WIDTH-1:0]      stride_feature_width;
  logic [DATA_WIDTH-1:0]      stride_feature_height;
  logic [DATA_WIDTH-1:0]      stride_kernel_sizeh;
  logic [DATA_WIDTH-1:0]      stride_kernel_sizew;
  logic [DATA_WIDTH-1:0]      stride_wb_ch_offset;
  logic                       stride_has_bias;
  logic                       stride_has_relu;
  logic                       inst_valid;
  logic                       decoder_ready;
  logic                       inst_err;

  // Tap stream and sideband
  logic [FRAM_ADDR_WIDTH-1:0] mac_fram_addr;
  logic [KRAM_ADDR_WIDTH-1:0] mac_kram_addr;
  logic [FRAM_ADDR_WIDTH-1:0] mac_wb_addr;
  logic                       mac_valid;
  logic                       mac_ready;
  logic                       mac_bias;
  logic                       mac_first;
  logic                       mac_last;
  logic                       mac_relu;

  modport master (
    output stride_feature_baseaddr, stride_kernel_baseaddr, stride_wb_baseaddr,
           stride_feature_chin, stride_feature_chout, stride_feature_width,
           stride_feature_height, stride_kernel_sizeh, stride_kernel_sizew,
           stride_wb_ch_offset, stride_has_bias, stride_has_relu,
           inst_valid, mac_ready,
    input  decoder_ready, inst_err, mac_fram_addr, mac_kram_addr, mac_wb_addr,
           mac_valid, mac_bias, mac_first, mac_last, mac_relu
  );

  modport slave (
    input  stride_feature_baseaddr, stride_kernel_baseaddr, stride_wb_baseaddr,
           stride_feature_chin, stride_feature_chout, stride_feature_width,
           stride_feature_height, stride_kernel_sizeh, stride_kernel_sizew,
           stride_wb_ch_offset, stride_has_bias, stride_has_relu,
           inst_valid, mac_ready,
    output decoder_ready, inst_err, mac_fram_addr, mac_kram_addr, mac_wb_addr,
           mac_valid, mac_bias, mac_first, mac_last, mac_relu
  );

endinterface

// File: rtl/stride_decoder.sv
// Convolution instruction decoder: expands one instruction into a stream of
// per-tap feature/kernel read addresses with bias/first/last/relu sideband.
// Ports:
//   clk  - sole clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - stride_decoder_if.slave: instruction handshake (inst_valid /
//          decoder_ready / inst_err) and tap stream (mac_valid / mac_ready
//          plus addresses and sideband). All bus outputs are registered.

`ifndef FRAM_ADDR_WIDTH
`define FRAM_ADDR_WIDTH 16
`endif
`ifndef KRAM_BANKADDR_WIDTH
`define KRAM_BANKADDR_WIDTH 12
`endif

module stride_decoder #(
  parameter int unsigned FRAM_ADDR_WIDTH = `FRAM_ADDR_WIDTH,
  parameter int unsigned KRAM_ADDR_WIDTH = `KRAM_BANKADDR_WIDTH,
  parameter int unsigned DATA_WIDTH      = 32
) (
  input  logic          clk,
  input  logic          rst,
  stride_decoder_if.slave bus
);

  localparam int unsigned FAW = FRAM_ADDR_WIDTH;
  localparam int unsigned KAW = KRAM_ADDR_WIDTH;
  localparam int unsigned DW  = DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Latched instruction
  logic [FAW-1:0] fbase_q, fbase_d;
  logic [KAW-1:0] kbase_q, kbase_d;
  logic [FAW-1:0] wbbase_q, wbbase_d;
  logic [DW-1:0]  chin_q, chin_d;
  logic [DW-1:0]  chout_q, chout_d;
  logic [DW-1:0]  width_q, width_d;
  logic [DW-1:0]  height_q, height_d;
  logic [DW-1:0]  kh_q, kh_d;
  logic [DW-1:0]  kw_q, kw_d;
  logic [DW-1:0]  wboff_q, wboff_d;
  logic           has_bias_q, has_bias_d;
  logic           has_relu_q, has_relu_d;

  // Per-instruction strides computed once in LOAD
  logic [DW-1:0]  plane_q, plane_d;
  logic [DW-1:0]  kblk_q, kblk_d;

  // Loop counters and running pointers
  logic [DW-1:0]  oc_q, oc_d;
  logic [DW-1:0]  ic_q, ic_d;
  logic [DW-1:0]  ky_q, ky_d;
  logic [DW-1:0]  kx_q, kx_d;
  logic [FAW-1:0] plane_ptr_q, plane_ptr_d;
  logic [FAW-1:0] row_ptr_q, row_ptr_d;
  logic [KAW-1:0] koc_ptr_q, koc_ptr_d;

  // Registered outputs
  logic           ready_q, ready_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic [FAW-1:0] fram_q, fram_d;
  logic [KAW-1:0] kram_q, kram_d;
  logic [FAW-1:0] wb_q, wb_d;
  logic           bias_q, bias_d;
  logic           first_q, first_d;
  logic           last_q, last_d;
  logic           relu_q, relu_d;

  logic           xfer;
  logic           run_done;
  logic [DW-1:0]  chin_m1, kh_m1, kw_m1, chout_m1;

  assign xfer     = valid_q && bus.mac_ready;
  assign chin_m1  = chin_q  - DW'(1);
  assign kh_m1    = kh_q    - DW'(1);
  assign kw_m1    = kw_q    - DW'(1);
  assign chout_m1 = chout_q - DW'(1);

  assign bus.decoder_ready = ready_q;
  assign bus.inst_err      = err_q;
  assign bus.mac_valid     = valid_q;
  assign bus.mac_fram_addr = fram_q;
  assign bus.mac_kram_addr = kram_q;
  assign bus.mac_wb_addr   = wb_q;
  assign bus.mac_bias      = bias_q;
  assign bus.mac_first     = first_q;
  assign bus.mac_last      = last_q;
  assign bus.mac_relu      = relu_q;

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    fbase_d     = fbase_q;
    kbase_d     = kbase_q;
    wbbase_d    = wbbase_q;
    chin_d      = chin_q;
    chout_d     = chout_q;
    width_d     = width_q;
    height_d    = height_q;
    kh_d        = kh_q;
    kw_d        = kw_q;
    wboff_d     = wboff_q;
    has_bias_d  = has_bias_q;
    has_relu_d  = has_relu_q;
    plane_d     = plane_q;
    kblk_d      = kblk_q;
    oc_d        = oc_q;
    ic_d        = ic_q;
    ky_d        = ky_q;
    kx_d        = kx_q;
    plane_ptr_d = plane_ptr_q;
    row_ptr_d   = row_ptr_q;
    koc_ptr_d   = koc_ptr_q;
    ready_d     = ready_q;
    valid_d     = valid_q;
    err_d       = 1'b0;
    fram_d      = fram_q;
    kram_d      = kram_q;
    wb_d        = wb_q;
    bias_d      = bias_q;
    first_d     = first_q;
    last_d      = last_q;
    relu_d      = relu_q;
    run_done    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.inst_valid && ready_q) begin
          fbase_d    = bus.stride_feature_baseaddr;
          kbase_d    = bus.stride_kernel_baseaddr;
          wbbase_d   = bus.stride_wb_baseaddr;
          chin_d     = bus.stride_feature_chin;
          chout_d    = bus.stride_feature_chout;
          width_d    = bus.stride_feature_width;
          height_d   = bus.stride_feature_height;
          kh_d       = bus.stride_kernel_sizeh;
          kw_d       = bus.stride_kernel_sizew;
          wboff_d    = bus.stride_wb_ch_offset;
          has_bias_d = bus.stride_has_bias;
          has_relu_d = bus.stride_has_relu;
          ready_d    = 1'b0;
          state_d    = LOAD;
        end
      end

      LOAD: begin
        plane_d = width_q * height_q;
        kblk_d  = chin_q * kh_q * kw_q + DW'(has_bias_q);
        oc_d    = '0;
        ic_d    = '0;
        ky_d    = '0;
        kx_d    = '0;
        if (chin_q == '0 || chout_q == '0 || kh_q == '0 || kw_q == '0) begin
          err_d   = 1'b1;
          ready_d = 1'b1;
          state_d = IDLE;
        end else begin
          // Preload tap 0; mac_valid rises one cycle after entering RUN
          plane_ptr_d = fbase_q;
          row_ptr_d   = fbase_q;
          koc_ptr_d   = kbase_q;
          fram_d      = fbase_q;
          kram_d      = kbase_q;
          wb_d        = wbbase_q;
          bias_d      = has_bias_q;
          first_d     = 1'b1;
          relu_d      = has_relu_q;
          last_d      = !has_bias_q && (chin_q == DW'(1)) &&
                        (kh_q == DW'(1)) && (kw_q == DW'(1));
          state_d     = RUN;
        end
      end

      RUN: begin
        if (!valid_q) begin
          valid_d = 1'b1;
        end else if (xfer) begin
          // Kernel words are contiguous across the whole instruction
          kram_d  = kram_q + KAW'(1);
          first_d = 1'b0;
          if (bias_q) begin
            bias_d = 1'b0;
            fram_d = fbase_q;
          end else if (kx_q != kw_m1) begin
            kx_d   = kx_q + DW'(1);
            fram_d = fram_q + FAW'(1);
          end else if (ky_q != kh_m1) begin
            kx_d      = '0;
            ky_d      = ky_q + DW'(1);
            row_ptr_d = row_ptr_q + FAW'(width_q);
            fram_d    = row_ptr_q + FAW'(width_q);
          end else if (ic_q != chin_m1) begin
            kx_d        = '0;
            ky_d        = '0;
            ic_d        = ic_q + DW'(1);
            plane_ptr_d = plane_ptr_q + FAW'(plane_q);
            row_ptr_d   = plane_ptr_q + FAW'(plane_q);
            fram_d      = plane_ptr_q + FAW'(plane_q);
          end else begin
            kx_d = '0;
            ky_d = '0;
            ic_d = '0;
            if (oc_q == chout_m1) begin
              run_done = 1'b1;
            end else begin
              oc_d        = oc_q + DW'(1);
              wb_d        = wb_q + FAW'(wboff_q);
              koc_ptr_d   = koc_ptr_q + KAW'(kblk_q);
              kram_d      = koc_ptr_q + KAW'(kblk_q);
              plane_ptr_d = fbase_q;
              row_ptr_d   = fbase_q;
              fram_d      = fbase_q;
              bias_d      = has_bias_q;
              first_d     = 1'b1;
            end
          end
          last_d = !bias_d && (kx_d == kw_m1) && (ky_d == kh_m1) && (ic_d == chin_m1);
          if (run_done) begin
            state_d = IDLE;
            ready_d = 1'b1;
            valid_d = 1'b0;
            fram_d  = '0;
            kram_d  = '0;
            wb_d    = '0;
            bias_d  = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
            relu_d  = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      fbase_q     <= '0;
      kbase_q     <= '0;
      wbbase_q    <= '0;
      chin_q      <= '0;
      chout_q     <= '0;
      width_q     <= '0;
      height_q    <= '0;
      kh_q        <= '0;
      kw_q        <= '0;
      wboff_q     <= '0;
      has_bias_q  <= 1'b0;
      has_relu_q  <= 1'b0;
      plane_q     <= '0;
      kblk_q      <= '0;
      oc_q        <= '0;
      ic_q        <= '0;
      ky_q        <= '0;
      kx_q        <= '0;
      plane_ptr_q <= '0;
      row_ptr_q   <= '0;
      koc_ptr_q   <= '0;
      ready_q     <= 1'b1;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      fram_q      <= '0;
      kram_q      <= '0;
      wb_q        <= '0;
      bias_q      <= 1'b0;
      first_q     <= 1'b0;
      last_q      <= 1'b0;
      relu_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      fbase_q     <= fbase_d;
      kbase_q     <= kbase_d;
      wbbase_q    <= wbbase_d;
      chin_q      <= chin_d;
      chout_q     <= chout_d;
      width_q     <= width_d;
      height_q    <= height_d;
      kh_q        <= kh_d;
      kw_q        <= kw_d;
      wboff_q     <= wboff_d;
      has_bias_q  <= has_bias_d;
      has_relu_q  <= has_relu_d;
      plane_q     <= plane_d;
      kblk_q      <= kblk_d;
      oc_q        <= oc_d;
      ic_q        <= ic_d;
      ky_q        <= ky_d;
      kx_q        <= kx_d;
      plane_ptr_q <= plane_ptr_d;
      row_ptr_q   <= row_ptr_d;
      koc_ptr_q   <= koc_ptr_d;
      ready_q     <= ready_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      fram_q      <= fram_d;
      kram_q      <= kram_d;
      wb_q        <= wb_d;
      bias_q      <= bias_d;
      first_q     <= first_d;
      last_q      <= last_d;
      relu_q      <= relu_d;
    end
  end

endmodule
